alu_mdu: RTL

ALU_MDU -- requirements
Module: alu_mdu

---
 rtl/alu_mdu.sv | 194 +++++++++++++++++++
 1 files changed

// File: rtl/alu_mdu.sv
// alu_mdu: integer ALU with a multiply/divide unit behind a valid/ready handshake.
// Multiplies finish in one cycle. Divides use a restoring divider that produces one quotient bit per cycle.
//
// state | meaning
// IDLE  | accepts requests; every non-divide op is computed and registered here
// DIV   | restoring divider runs, one quotient bit per cycle, counter WIDTH-1..0
// FIX   | applies the signs to quotient/remainder and registers the result
module alu_mdu #(
  parameter int WIDTH  = 32,
  parameter int DIV_EN = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [4:0]       ALUop,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] ALUS,
  output logic             zero
);

  localparam int SW = $clog2(WIDTH);
  localparam logic [WIDTH-1:0] MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic [WIDTH-1:0] ALL_ONES = '1;

  typedef enum logic [1:0] {IDLE, DIV, FIX} state_t;

  state_t             state;
  logic [SW-1:0]      cnt;
  logic [WIDTH-1:0]   quo;
  logic [WIDTH-1:0]   rem_r;
  logic [WIDTH-1:0]   dvs;
  logic               q_neg;
  logic               r_neg;
  logic               is_rem;

  logic               accept;
  logic               go_div;
  logic [SW-1:0]      shamt;
  logic [WIDTH-1:0]   alu_res;
  logic [2*WIDTH-1:0] mul_a;
  logic [2*WIDTH-1:0] mul_b;
  logic [2*WIDTH-1:0] mul_p;
  logic [WIDTH-1:0]   m_res;
  logic               div_signed;
  logic               div_rem;
  logic               div_start;
  logic [WIDTH-1:0]   div_res;
  logic [WIDTH-1:0]   a_mag;
  logic [WIDTH-1:0]   b_mag;
  logic [WIDTH-1:0]   comb_res;
  logic [WIDTH:0]     shifted;
  logic [WIDTH:0]     diff;
  logic [WIDTH-1:0]   q_fix;
  logic [WIDTH-1:0]   r_fix;
  logic [WIDTH-1:0]   fix_res;

  assign in_ready = (state == IDLE) && (!out_valid || out_ready);
  assign accept   = in_valid && in_ready;
  assign go_div   = ALUop[4] && !ALUop[3] && ALUop[2] && div_start;

  // Base integer group; the shift amount is taken from the low log2(WIDTH) bits of B only
  always_comb begin
    shamt = B[SW-1:0];
    case (ALUop[3:0])
      4'b0000: alu_res = A + B;
      4'b1000: alu_res = A - B;
      4'b0001: alu_res = A << shamt;
      4'b0010: alu_res = {{(WIDTH-1){1'b0}}, ($signed(A) < $signed(B))};
      4'b0011: alu_res = {{(WIDTH-1){1'b0}}, (A < B)};
      4'b0100: alu_res = A ^ B;
      4'b0101: alu_res = A >> shamt;
      4'b1101: alu_res = $unsigned($signed(A) >>> shamt);
      4'b0110: alu_res = A | B;
      4'b0111: alu_res = A & B;
      default: alu_res = '0;
    endcase
  end

  // Multiplier: extend each operand to 2*WIDTH as the variant requires; the low 2*WIDTH product bits are exact
  always_comb begin
    mul_a = {{WIDTH{((ALUop[1:0] == 2'b01) || (ALUop[1:0] == 2'b10)) && A[WIDTH-1]}}, A};
    mul_b = {{WIDTH{(ALUop[1:0] == 2'b01) && B[WIDTH-1]}}, B};
    mul_p = mul_a * mul_b;
    m_res = (ALUop[1:0] == 2'b00) ? mul_p[WIDTH-1:0] : mul_p[2*WIDTH-1:WIDTH];
  end

  // Divide front end: resolve the single-cycle special cases and form the operand magnitudes
  always_comb begin
    div_signed = ~ALUop[0];
    div_rem    = ALUop[1];
    a_mag      = (div_signed && A[WIDTH-1]) ? -A : A;
    b_mag      = (div_signed && B[WIDTH-1]) ? -B : B;
    div_start  = 1'b0;
    div_res    = '0;
    if (DIV_EN != 0) begin
      if (B == '0) begin
        div_res = div_rem ? A : ALL_ONES;
      end else if (div_signed && (A == MOST_NEG) && (B == ALL_ONES)) begin
        div_res = div_rem ? '0 : A;
      end else begin
        div_start = 1'b1;
      end
    end
  end

  // Select the result for an op that completes in the accepting cycle
  always_comb begin
    if (!ALUop[4]) begin
      comb_res = alu_res;
    end else if (ALUop[3]) begin
      comb_res = '0;
    end else if (!ALUop[2]) begin
      comb_res = m_res;
    end else begin
      comb_res = div_res;
    end
  end

  // Restoring step and final sign fix-up. The partial remainder is always below the divisor, so WIDTH bits hold it
  always_comb begin
    shifted = {rem_r, quo[WIDTH-1]};
    diff    = shifted - {1'b0, dvs};
    q_fix   = q_neg ? -quo : quo;
    r_fix   = r_neg ? -rem_r : rem_r;
    fix_res = is_rem ? r_fix : q_fix;
  end

  // Control FSM, divider datapath and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      out_valid <= 1'b0;
      ALUS      <= '0;
      zero      <= 1'b0;
      cnt       <= '0;
      quo       <= '0;
      rem_r     <= '0;
      dvs       <= '0;
      q_neg     <= 1'b0;
      r_neg     <= 1'b0;
      is_rem    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            if (go_div) begin
              state     <= DIV;
              out_valid <= 1'b0;
              cnt       <= SW'(WIDTH-1);
              quo       <= a_mag;
              rem_r     <= '0;
              dvs       <= b_mag;
              q_neg     <= div_signed && (A[WIDTH-1] ^ B[WIDTH-1]);
              r_neg     <= div_signed && A[WIDTH-1];
              is_rem    <= div_rem;
            end else begin
              ALUS      <= comb_res;
              zero      <= (comb_res == '0);
              out_valid <= 1'b1;
            end
          end else if (out_valid && out_ready) begin
            out_valid <= 1'b0;
          end
        end
        DIV: begin
          if (!diff[WIDTH]) begin
            rem_r <= diff[WIDTH-1:0];
            quo   <= {quo[WIDTH-2:0], 1'b1};
          end else begin
            rem_r <= shifted[WIDTH-1:0];
            quo   <= {quo[WIDTH-2:0], 1'b0};
          end
          if (cnt == '0) begin
            state <= FIX;
          end else begin
            cnt <= cnt - SW'(1);
          end
        end
        FIX: begin
          ALUS      <= fix_res;
          zero      <= (fix_res == '0);
          out_valid <= 1'b1;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
